// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC generation, a single-entry skid
// buffer absorbing decode back-pressure, and branch redirect with discard of
// an in-flight memory response.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | request outstanding at req_addr; IF/ID loads when it returns
// HOLD  | decode stalled with a returned word parked in the skid buffer
// DROP  | redirect seen while a request was pending; its data is thrown away
module fetch_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_d,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_ready,
  output logic [31:0]  instr_d,
  output logic [N-1:0] pc_d,
  output logic         valid_d
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  localparam logic [N-1:0] PC_STEP = N'(4);

  state_t         state, state_nxt;
  logic [N-1:0]   pc_f, pc_f_nxt;
  logic [N-1:0]   req_addr, req_addr_nxt;
  logic [31:0]    skid_instr, skid_instr_nxt;
  logic [N-1:0]   skid_pc, skid_pc_nxt;
  logic           skid_valid, skid_valid_nxt;
  logic [31:0]    instr_nxt;
  logic [N-1:0]   pc_d_nxt;
  logic           valid_nxt;
  logic [N-1:0]   target;
  logic [N-1:0]   addr_inc;

  assign target    = {branch_target[N-1:2], 2'b00};
  assign addr_inc  = req_addr + PC_STEP;
  assign imem_addr = req_addr;

  // Memory is requested whenever a fetch or a to-be-dropped request is live.
  assign imem_req  = !reset && (state != HOLD);

  // Next-state and register-update decisions; a redirect overrides everything.
  always_comb begin
    state_nxt      = state;
    pc_f_nxt       = pc_f;
    req_addr_nxt   = req_addr;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    skid_valid_nxt = skid_valid;
    instr_nxt      = instr_d;
    pc_d_nxt       = pc_d;
    valid_nxt      = valid_d;

    if (branch_taken) begin
      pc_f_nxt       = target;
      valid_nxt      = 1'b0;
      instr_nxt      = '0;
      skid_valid_nxt = 1'b0;
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            req_addr_nxt = target;
            state_nxt    = FETCH;
          end else begin
            state_nxt    = DROP;
          end
        end
        HOLD: begin
          req_addr_nxt = target;
          state_nxt    = FETCH;
        end
        DROP: begin
          // The stale request finishing in the same cycle lets us restart
          // straight at the newest target.
          if (imem_ready) begin
            req_addr_nxt = target;
            state_nxt    = FETCH;
          end
        end
        default: begin
          req_addr_nxt = target;
          state_nxt    = FETCH;
        end
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_f_nxt = addr_inc;
            if (stall_d) begin
              skid_instr_nxt = imem_rdata;
              skid_pc_nxt    = req_addr;
              skid_valid_nxt = 1'b1;
              state_nxt      = HOLD;
            end else begin
              instr_nxt    = imem_rdata;
              pc_d_nxt     = req_addr;
              valid_nxt    = 1'b1;
              req_addr_nxt = addr_inc;
            end
          end else if (!stall_d) begin
            valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_d) begin
            instr_nxt      = skid_instr;
            pc_d_nxt       = skid_pc;
            valid_nxt      = skid_valid;
            skid_valid_nxt = 1'b0;
            req_addr_nxt   = pc_f;
            state_nxt      = FETCH;
          end
        end
        DROP: begin
          if (imem_ready) begin
            req_addr_nxt = pc_f;
            state_nxt    = FETCH;
          end
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc_f       <= '0;
      req_addr   <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_valid <= 1'b0;
      instr_d    <= '0;
      pc_d       <= '0;
      valid_d    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_f       <= pc_f_nxt;
      req_addr   <= req_addr_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_valid <= skid_valid_nxt;
      instr_d    <= instr_nxt;
      pc_d       <= pc_d_nxt;
      valid_d    <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios against fixed expectations, then
// a long randomized run against a transaction-level reference model.
module tb_fetch_stage;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         stall_d;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic [31:0]  imem_rdata;
  logic         imem_ready;
  logic [31:0]  instr_d;
  logic [N-1:0] pc_d;
  logic         valid_d;

  int errors = 0;
  int checks = 0;

  // reference model: what the pipeline should look like
  logic [N-1:0] m_addr;     // address currently being requested
  logic [N-1:0] m_next;     // where fetch continues after a parked/dropped word
  logic         m_wait;     // a fetched word is parked waiting for decode
  logic         m_discard;  // the pending request's data must be thrown away
  logic [31:0]  m_bi;
  logic [N-1:0] m_bpc;
  logic         m_valid;
  logic [31:0]  m_instr;
  logic [N-1:0] m_pc;

  fetch_stage #(.N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_d       (stall_d),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .valid_d       (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [N-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic cycle(input logic rst, input logic stl, input logic br,
                       input logic [N-1:0] tgt, input logic rdy);
    logic [31:0]  rd;
    logic [N-1:0] t;
    reset         = rst;
    stall_d       = stl;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    rd            = rdy ? pat(imem_addr) : $urandom();
    imem_rdata    = rd;
    @(posedge clk);
    t = {tgt[N-1:2], 2'b00};
    if (rst) begin
      m_addr = '0; m_next = '0; m_wait = 0; m_discard = 0;
      m_valid = 0; m_instr = '0; m_pc = '0;
    end else if (br) begin
      m_next = t; m_valid = 0; m_instr = '0;
      if (m_wait) begin
        m_addr = t; m_wait = 0;
      end else if (rdy) begin
        m_addr = t; m_discard = 0;
      end else begin
        m_discard = 1;
      end
    end else if (m_wait) begin
      if (!stl) begin
        m_valid = 1; m_instr = m_bi; m_pc = m_bpc; m_addr = m_next; m_wait = 0;
      end
    end else if (m_discard) begin
      if (rdy) begin
        m_addr = m_next; m_discard = 0;
      end
    end else if (rdy) begin
      if (stl) begin
        m_bi = rd; m_bpc = m_addr; m_next = m_addr + 64'd4; m_wait = 1;
      end else begin
        m_valid = 1; m_instr = rd; m_pc = m_addr;
        m_addr = m_addr + 64'd4; m_next = m_addr;
      end
    end else if (!stl) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 1);
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 64'h55, 1);
    cycle(1, 0, 1, 64'h77, 0);
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_d); end
    checks++; if (pc_d !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_d); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    reset = 0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL post_reset_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, '0, 1);
      checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, valid_d); end
      checks++; if (pc_d !== 64'(4*i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc_d, 64'(4*i)); end
      checks++; if (instr_d !== pat(64'(4*i))) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr_d, pat(64'(4*i))); end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, '0, 0);
      checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL wait_addr[%0d]: got %h want 8", i, imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
      checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b want 0", i, valid_d); end
    end
    cycle(0, 0, 0, '0, 1);
    checks++; if (valid_d !== 1'b1 || pc_d !== 64'h8) begin errors++; $display("FAIL wait_done: got valid=%b pc=%h want valid=1 pc=8", valid_d, pc_d); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1);
    checks++; if (imem_addr !== 64'h10) begin errors++; $display("FAIL stall_pre_addr: got %h want 10", imem_addr); end
    cycle(0, 1, 0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
      checks++; if (pc_d !== 64'hC || valid_d !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got pc=%h valid=%b want pc=c valid=1", i, pc_d, valid_d); end
      if (i < 3) cycle(0, 1, 0, '0, 0);
    end
    cycle(0, 0, 0, '0, 0);
    checks++; if (pc_d !== 64'h10 || valid_d !== 1'b1) begin errors++; $display("FAIL stall_release: got pc=%h valid=%b want pc=10 valid=1", pc_d, valid_d); end
    checks++; if (instr_d !== pat(64'h10)) begin errors++; $display("FAIL stall_skid_instr: got %h want %h", instr_d, pat(64'h10)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h14) begin errors++; $display("FAIL stall_refetch: got req=%b addr=%h want req=1 addr=14", imem_req, imem_addr); end
    cycle(0, 0, 0, '0, 1);
    checks++; if (pc_d !== 64'h14 || valid_d !== 1'b1) begin errors++; $display("FAIL stall_next: got pc=%h valid=%b want pc=14 valid=1", pc_d, valid_d); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 1, 64'h103, 0);
    checks++; if (valid_d !== 1'b0 || instr_d !== 32'h0) begin errors++; $display("FAIL drop_flush: got valid=%b instr=%h want 0/0", valid_d, instr_d); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h20) begin errors++; $display("FAIL drop_keep: got req=%b addr=%h want req=1 addr=20", imem_req, imem_addr); end
    cycle(0, 0, 0, '0, 1);
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL drop_discard: got valid=%b want 0", valid_d); end
    checks++; if (imem_addr !== 64'h100) begin errors++; $display("FAIL drop_target: got %h want 100", imem_addr); end
    cycle(0, 0, 0, '0, 0);
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL drop_wait: got valid=%b want 0", valid_d); end
    cycle(0, 0, 0, '0, 1);
    checks++; if (valid_d !== 1'b1 || pc_d !== 64'h100 || instr_d !== pat(64'h100)) begin errors++; $display("FAIL drop_arrive: got valid=%b pc=%h instr=%h want 1/100/%h", valid_d, pc_d, instr_d, pat(64'h100)); end
  endtask

  task automatic test_flush_in_hold();
    do_reset();
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 1, 0, '0, 1);
    cycle(0, 1, 1, 64'h42, 1);
    checks++; if (valid_d !== 1'b0 || instr_d !== 32'h0) begin errors++; $display("FAIL hold_flush: got valid=%b instr=%h want 0/0", valid_d, instr_d); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h40) begin errors++; $display("FAIL hold_restart: got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr); end
    cycle(0, 0, 0, '0, 1);
    checks++; if (valid_d !== 1'b1 || pc_d !== 64'h40) begin errors++; $display("FAIL hold_target: got valid=%b pc=%h want 1/40", valid_d, pc_d); end
  endtask

  task automatic test_reset_mid_request();
    do_reset();
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 0);
    cycle(0, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 1);
    checks++; if (valid_d !== 1'b0 || instr_d !== 32'h0 || pc_d !== 64'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got valid=%b instr=%h pc=%h req=%b want all 0", valid_d, instr_d, pc_d, imem_req); end
    reset = 0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL midreset_first: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    cycle(0, 0, 0, '0, 1);
    checks++; if (valid_d !== 1'b1 || pc_d !== 64'h0) begin errors++; $display("FAIL midreset_fetch: got valid=%b pc=%h want 1/0", valid_d, pc_d); end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(0, 0, 1, {N{1'b1}}, 1);
    checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffffffffffc", imem_addr); end
    cycle(0, 0, 0, '0, 1);
    checks++; if (pc_d !== 64'hFFFF_FFFF_FFFF_FFFC || imem_addr !== 64'h0) begin errors++; $display("FAIL wrap_step: got pc=%h addr=%h want fffffffffffffffc/0", pc_d, imem_addr); end
    cycle(0, 0, 0, '0, 1);
    checks++; if (pc_d !== 64'h0 || valid_d !== 1'b1) begin errors++; $display("FAIL wrap_zero: got pc=%h valid=%b want 0/1", pc_d, valid_d); end
  endtask

  task automatic test_random();
    logic         r, s, b, y;
    logic [N-1:0] t;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 9) == 0);
      y = ($urandom_range(0, 1) == 0);
      t = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) t = {{(N-12){1'b0}}, t[11:0]};
      cycle(r, s, b, t, y);
      reset = 0;
      #1;
      checks++; if (valid_d !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, valid_d, m_valid); end
      checks++; if (instr_d !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, instr_d, m_instr); end
      checks++; if (pc_d !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_d, m_pc); end
      checks++; if (imem_req !== !m_wait) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, !m_wait); end
      checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, m_addr); end
      if (valid_d === 1'b1) begin
        checks++; if (instr_d !== pat(pc_d)) begin errors++; $display("FAIL rnd_pairing[%0d]: instr %h for pc %h, want %h", i, instr_d, pc_d, pat(pc_d)); end
      end
    end
  endtask

  initial begin
    reset = 1; stall_d = 0; branch_taken = 0; branch_target = '0;
    imem_ready = 0; imem_rdata = '0;
    m_addr = '0; m_next = '0; m_wait = 0; m_discard = 0;
    m_bi = '0; m_bpc = '0; m_valid = 0; m_instr = '0; m_pc = '0;
    #1;
    test_reset();
    test_streaming();
    test_wait_states();
    test_stall();
    test_redirect_drop();
    test_flush_in_hold();
    test_reset_mid_request();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
